// File: rtl/sc_run_controller.sv
// sc_run_controller: streams a program into instruction memory, holds the core
// in reset, then runs it until it halts or exhausts its cycle budget, capturing
// a signature word stored by the program.
module sc_run_controller #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CNT_WIDTH  = 16,
  parameter int unsigned           MAX_CYCLES = 500,
  parameter int unsigned           RESET_HOLD = 2,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(32'h0000_006F),
  parameter logic [ADDR_WIDTH-1:0] SIG_ADDR   = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset_n,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  d_rw,
  input  logic [DATA_WIDTH-1:0] ddata_w,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycles,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  hs;
  logic                  halt;
  logic                  at_budget;
  logic                  sig_store;
  logic                  restart;
  logic                  unused_iaddr;

  assign hs        = ld_valid && (state == S_LOAD);
  assign halt      = (idata == HALT_WORD);
  assign at_budget = (cycles == CNT_LAST);
  assign sig_store = d_rw && (daddr == SIG_ADDR);
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE));

  // Fetch address is observed by the bench only, never used for control.
  assign unused_iaddr = ^iaddr;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; halt takes priority over the budget check.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (hs && (ld_last || (load_addr == ADDR_MAX))) state_next = S_HOLD;
      S_HOLD:  if (hold_cnt == HOLD_LAST) state_next = S_RUN;
      S_RUN:   if (halt || at_budget) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the imem port is live only on a load handshake.
  always_comb begin
    ld_ready    = 1'b0;
    imem_we     = 1'b0;
    imem_waddr  = '0;
    imem_wdata  = '0;
    cpu_reset_n = 1'b0;
    busy        = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          imem_we    = 1'b1;
          imem_waddr = load_addr;
          imem_wdata = ld_data;
        end
      end
      S_HOLD: busy = 1'b1;
      S_RUN: begin
        busy        = 1'b1;
        cpu_reset_n = 1'b1;
      end
      default: ;
    endcase
  end

  // Load address, hold counter, cycle counter and sticky run status.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_addr    <= '0;
      hold_cnt     <= '0;
      cycles       <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      hold_cnt <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      if (restart) begin
        load_addr    <= '0;
        cycles       <= '0;
        done         <= 1'b0;
        timeout      <= 1'b0;
        result       <= '0;
        result_valid <= 1'b0;
      end
      case (state)
        S_LOAD: begin
          // Saturate at the top address: the transition to HOLD ends the load.
          if (hs && (load_addr != ADDR_MAX)) begin
            load_addr <= load_addr + ADDR_WIDTH'(1);
          end
        end
        S_HOLD: cycles <= '0;
        S_RUN: begin
          if (halt) begin
            done <= 1'b1;
          end else if (at_budget) begin
            timeout <= 1'b1;
            cycles  <= CNT_MAX;
          end else begin
            cycles <= cycles + CNT_WIDTH'(1);
          end
          if (sig_store) begin
            result       <= ddata_w;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_run_controller.sv
// Bench for sc_run_controller: a ROM-driven core model feeds fetches and stores,
// and a per-cycle program model predicts halt/timeout, cycle count and signature.
module tb_sc_run_controller;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned MAXC = 500;
  localparam int unsigned RH   = 2;
  localparam logic [DW-1:0] HALT = 32'h0000_006F;
  localparam logic [DW-1:0] NOP  = 32'h0000_0013;
  localparam logic [AW-1:0] SIG  = {AW{1'b1}};

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          start = 1'b0;
  logic          start_s = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] idata, ddata_w;
  logic          d_rw;

  logic          ld_ready, imem_we, cpu_reset_n, busy, done, timeout, result_valid;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata, result;
  logic [CW-1:0] cycles;

  logic          ld_ready_s, imem_we_s, cpu_reset_n_s, busy_s, done_s, timeout_s, result_valid_s;
  logic [3:0]    imem_waddr_s;
  logic [DW-1:0] imem_wdata_s, result_s;
  logic [CW-1:0] cycles_s;

  int checks = 0;
  int errors = 0;

  // Program image seen by the core: instruction plus a store action per pc.
  // kind: 0 none, 1 store to SIG, 2 store elsewhere, 3 read of SIG
  logic [DW-1:0] rom     [0:1023];
  int            st_kind [0:1023];
  logic [DW-1:0] st_data [0:1023];
  logic [AW-1:0] pc;

  always #5 CLK = ~CLK;

  // Core model: pc restarts from 0 whenever the core is held in reset.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)          pc <= '0;
    else if (!cpu_reset_n) pc <= '0;
    else                   pc <= pc + 1'b1;
  end

  assign iaddr   = pc;
  assign idata   = rom[pc];
  assign d_rw    = (st_kind[pc] == 1) || (st_kind[pc] == 2);
  assign daddr   = ((st_kind[pc] == 1) || (st_kind[pc] == 3)) ? SIG : pc;
  assign ddata_w = st_data[pc];

  sc_run_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_CYCLES(MAXC),
    .RESET_HOLD(RH), .HALT_WORD(HALT), .SIG_ADDR(SIG)
  ) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .d_rw(d_rw), .ddata_w(ddata_w), .busy(busy), .done(done), .timeout(timeout),
    .cycles(cycles), .result(result), .result_valid(result_valid)
  );

  sc_run_controller #(.ADDR_WIDTH(4)) u_small (
    .CLK(CLK), .RESET_N(RESET_N), .start(start_s), .ld_valid(ld_valid),
    .ld_ready(ld_ready_s), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we_s), .imem_waddr(imem_waddr_s), .imem_wdata(imem_wdata_s),
    .cpu_reset_n(cpu_reset_n_s), .iaddr(pc[3:0]), .idata(idata), .daddr(daddr[3:0]),
    .d_rw(d_rw), .ddata_w(ddata_w), .busy(busy_s), .done(done_s), .timeout(timeout_s),
    .cycles(cycles_s), .result(result_s), .result_valid(result_valid_s)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      rom[i]     = NOP;
      st_kind[i] = 0;
      st_data[i] = $urandom;
    end
  endtask

  // Walk the program cycle by cycle from run cycle 0 applying the run rules.
  task automatic model_run(output bit m_done, output bit m_to, output int m_cyc,
                           output logic [DW-1:0] m_res, output bit m_rv);
    bit stop;
    m_done = 0; m_to = 0; m_cyc = 0; m_res = '0; m_rv = 0; stop = 0;
    for (int k = 0; k < int'(MAXC) && !stop; k++) begin
      if (st_kind[k] == 1) begin m_res = st_data[k]; m_rv = 1; end
      if (rom[k] == HALT) begin
        m_done = 1; m_cyc = k; stop = 1;
      end else if (k == int'(MAXC) - 1) begin
        m_to = 1; m_cyc = int'(MAXC); stop = 1;
      end
    end
  endtask

  // Start a load of rom[0..n-1], check every imem write and the hold timing.
  // Entered and left on a falling edge; leaves the DUT in its first RUN cycle.
  task automatic load_and_check(input int n, input bit use_last, input bit gaps);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if ({ld_ready, busy, done, timeout, result_valid, cycles, result} !== {1'b1, 1'b1, 3'b000, CW'(0), DW'(0)}) begin
      errors++;
      $display("FAIL load_entry: rdy=%b busy=%b done=%b to=%b rv=%b cyc=%0d res=%h, expected rdy=1 busy=1 and cleared status",
               ld_ready, busy, done, timeout, result_valid, cycles, result);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        #1;
        checks++;
        if (imem_we !== 1'b0) begin
          errors++; $display("FAIL load_gap_we: got %b expected 0", imem_we);
        end
        @(negedge CLK);
      end
      ld_valid = 1'b1;
      ld_data  = rom[i];
      ld_last  = use_last && (i == n - 1);
      #1;
      checks++;
      if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, AW'(i), rom[i]}) begin
        errors++;
        $display("FAIL load_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 i, imem_we, imem_waddr, imem_wdata, i, rom[i]);
      end
      @(negedge CLK);
    end
    ld_last = 1'b0;
    for (int e = 1; e <= int'(RH); e++) begin
      ld_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({cpu_reset_n, ld_ready, imem_we, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL hold[%0d]: got rst_n=%b rdy=%b we=%b busy=%b expected 0,0,0,1",
                 e, cpu_reset_n, ld_ready, imem_we, busy);
      end
      @(negedge CLK);
    end
    ld_valid = 1'b0;
    checks++;
    if ({cpu_reset_n, busy, cycles} !== {1'b1, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL release: got rst_n=%b busy=%b cycles=%0d expected 1,1,0", cpu_reset_n, busy, cycles);
    end
  endtask

  // Let the run finish and compare end time and status with the program model.
  task automatic run_and_check(input string name, input bit poke);
    bit m_done, m_to, m_rv;
    int m_cyc, exp_edges, edges;
    logic [DW-1:0] m_res;
    model_run(m_done, m_to, m_cyc, m_res, m_rv);
    exp_edges = m_done ? m_cyc + 1 : int'(MAXC);
    edges = 0;
    while (!(done === 1'b1 || timeout === 1'b1) && edges < 2000) begin
      start = poke && (edges == 5);
      @(negedge CLK);
      edges++;
    end
    start = 1'b0;
    checks++;
    if (edges != exp_edges) begin
      errors++; $display("FAIL %s_end_edge: got %0d expected %0d", name, edges, exp_edges);
    end
    checks++;
    if ({done, timeout, cycles} !== {m_done, m_to, CW'(m_cyc)}) begin
      errors++;
      $display("FAIL %s_status: got done=%b to=%b cyc=%0d expected done=%b to=%b cyc=%0d",
               name, done, timeout, cycles, m_done, m_to, m_cyc);
    end
    checks++;
    if ({result_valid, result} !== {m_rv, m_res}) begin
      errors++;
      $display("FAIL %s_result: got rv=%b res=%h expected rv=%b res=%h", name, result_valid, result, m_rv, m_res);
    end
    checks++;
    if ({cpu_reset_n, busy, ld_ready} !== 3'b000) begin
      errors++;
      $display("FAIL %s_frozen: got rst_n=%b busy=%b rdy=%b expected 0,0,0", name, cpu_reset_n, busy, ld_ready);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if ({done, timeout, cycles, result_valid, result} !== {m_done, m_to, CW'(m_cyc), m_rv, m_res}) begin
      errors++;
      $display("FAIL %s_sticky: got done=%b to=%b cyc=%0d rv=%b res=%h", name, done, timeout, cycles, result_valid, result);
    end
  endtask

  task automatic test_reset();
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({cpu_reset_n, ld_ready, imem_we, busy, done, timeout, result_valid, imem_waddr, imem_wdata, cycles, result} !== '0) begin
      errors++;
      $display("FAIL reset_values: rst_n=%b rdy=%b we=%b busy=%b done=%b to=%b rv=%b addr=%h wd=%h cyc=%h res=%h expected all 0",
               cpu_reset_n, ld_ready, imem_we, busy, done, timeout, result_valid, imem_waddr, imem_wdata, cycles, result);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({cpu_reset_n, ld_ready, imem_we, busy, done, timeout, cycles} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: rst_n=%b rdy=%b we=%b busy=%b done=%b to=%b cyc=%0d expected all 0",
               cpu_reset_n, ld_ready, imem_we, busy, done, timeout, cycles);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_halt_basic();
    clear_prog();
    rom[0] = 32'h0010_0093;
    rom[1] = NOP;
    rom[2] = HALT;
    load_and_check(3, 1'b1, 1'b0);
    run_and_check("halt_basic", 1'b0);
    checks++;
    if ({done, timeout, cycles} !== {1'b1, 1'b0, CW'(2)}) begin
      errors++; $display("FAIL halt_basic_const: got done=%b to=%b cyc=%0d expected 1,0,2", done, timeout, cycles);
    end
  endtask

  task automatic test_timeout();
    clear_prog();
    load_and_check(5, 1'b1, 1'b1);
    run_and_check("timeout", 1'b1);
    checks++;
    if ({done, timeout, cycles} !== {1'b0, 1'b1, CW'(500)}) begin
      errors++; $display("FAIL timeout_const: got done=%b to=%b cyc=%0d expected 0,1,500", done, timeout, cycles);
    end
  endtask

  task automatic test_signature();
    clear_prog();
    st_kind[10] = 1; st_data[10] = 32'h0000_0001;
    st_kind[40] = 1; st_data[40] = 32'h0000_0BAD;
    st_kind[50] = 2;
    st_kind[55] = 3;
    rom[60] = HALT;
    load_and_check(4, 1'b1, 1'b1);
    run_and_check("signature", 1'b0);
    checks++;
    if ({done, result_valid, result} !== {1'b1, 1'b1, 32'h0000_0BAD}) begin
      errors++; $display("FAIL signature_const: got done=%b rv=%b res=%h expected 1,1,00000bad", done, result_valid, result);
    end
  endtask

  task automatic test_halt_boundary();
    clear_prog();
    rom[499] = HALT;
    st_kind[499] = 1;
    load_and_check(2, 1'b1, 1'b0);
    run_and_check("halt_boundary", 1'b0);
    checks++;
    if ({done, timeout, cycles} !== {1'b1, 1'b0, CW'(499)}) begin
      errors++; $display("FAIL halt_boundary_const: got done=%b to=%b cyc=%0d expected 1,0,499", done, timeout, cycles);
    end
  endtask

  task automatic test_random();
    int hpos, r;
    for (int it = 0; it < 6; it++) begin
      clear_prog();
      for (int k = 0; k < 1024; k++) begin
        r = $urandom_range(0, 19);
        if (r < 4)       rom[k] = 32'h0000_00EF;
        else if (r < 12) rom[k] = ($urandom == HALT) ? NOP : $urandom;
        r = $urandom_range(0, 9);
        if (r < 3) st_kind[k] = r + 1;
      end
      hpos = $urandom_range(0, 600);
      rom[hpos] = HALT;
      if (it % 2 == 0) st_kind[hpos] = 1;
      load_and_check($urandom_range(1, 8), 1'b1, 1'b1);
      run_and_check("random", 1'b1);
    end
  endtask

  task automatic test_small_addr();
    int count;
    logic [DW-1:0] wd;
    start_s = 1'b1;
    @(negedge CLK);
    start_s = 1'b0;
    count = 0;
    for (int j = 0; j < 64 && count < 16; j++) begin
      ld_valid = (j % 2 == 0);
      ld_last  = 1'b0;
      wd       = $urandom;
      ld_data  = wd;
      #1;
      checks++;
      if (ld_valid) begin
        if ({ld_ready_s, imem_we_s, imem_waddr_s, imem_wdata_s} !== {1'b1, 1'b1, 4'(count), wd}) begin
          errors++;
          $display("FAIL small_write[%0d]: got rdy=%b we=%b addr=%0d data=%h expected 1,1,%0d,%h",
                   count, ld_ready_s, imem_we_s, imem_waddr_s, imem_wdata_s, count, wd);
        end
        count++;
      end else if ({imem_we_s, imem_we} !== 2'b00) begin
        errors++; $display("FAIL small_idle_we: got we_s=%b we=%b expected 0,0", imem_we_s, imem_we);
      end
      @(negedge CLK);
    end
    ld_valid = 1'b1;
    #1;
    checks++;
    if ({ld_ready_s, imem_we_s, busy_s, cpu_reset_n_s} !== 4'b0010) begin
      errors++;
      $display("FAIL small_hold: got rdy=%b we=%b busy=%b rst_n=%b expected 0,0,1,0",
               ld_ready_s, imem_we_s, busy_s, cpu_reset_n_s);
    end
    @(negedge CLK);
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    load_and_check(4, 1'b1, 1'b1);
    repeat (100) @(negedge CLK);
    checks++;
    if ({cycles, busy, cpu_reset_n} !== {CW'(100), 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_run_count: got cyc=%0d busy=%b rst_n=%b expected 100,1,1", cycles, busy, cpu_reset_n);
    end
    RESET_N  = 1'b0;
    ld_valid = 1'b1;
    #1;
    checks++;
    if ({cpu_reset_n, ld_ready, imem_we, busy, done, timeout, result_valid, imem_waddr, imem_wdata, cycles, result} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: rst_n=%b rdy=%b we=%b busy=%b done=%b to=%b rv=%b addr=%h wd=%h cyc=%h res=%h expected all 0",
               cpu_reset_n, ld_ready, imem_we, busy, done, timeout, result_valid, imem_waddr, imem_wdata, cycles, result);
    end
    @(negedge CLK);
    RESET_N  = 1'b1;
    @(negedge CLK);
    checks++;
    if ({cpu_reset_n, ld_ready, imem_we, busy, cycles} !== '0) begin
      errors++;
      $display("FAIL mid_run_idle: rst_n=%b rdy=%b we=%b busy=%b cyc=%0d expected all 0",
               cpu_reset_n, ld_ready, imem_we, busy, cycles);
    end
    ld_valid = 1'b0;
    rom[3] = HALT;
    st_kind[1] = 1; st_data[1] = 32'h1234_5678;
    load_and_check(4, 1'b1, 1'b1);
    run_and_check("reload", 1'b0);
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_halt_basic();
    test_timeout();
    test_signature();
    test_halt_boundary();
    test_random();
    test_small_addr();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
